// File: rtl/lv_bist_pkg.sv
// lv_bist_pkg
//   Shared types and constants for the LV logic BIST sequencer:
//   - lv_bist_st_e : sequencer FSM state encoding
//   - BIST_FC_*    : bit positions inside the fail code
//   - BIST_FC_W    : fail-code width
//   - max2()       : elaboration-time helper for sizing the shared timer
package lv_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_EVAL = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } lv_bist_st_e;

    localparam int BIST_FC_W    = 4;
    localparam int BIST_FC_OWT  = 0;
    localparam int BIST_FC_SCAN = 1;
    localparam int BIST_FC_INTB = 2;
    localparam int BIST_FC_WDG  = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lv_bist_tmr.sv
// lv_bist_tmr
//   Loadable saturating down-counter with a terminal-count flag.
//   Ports:
//     i_clk, i_rst  : clock, synchronous active-high reset (count -> 0)
//     i_load        : load i_load_val this cycle (wins over counting)
//     i_load_val    : value to load
//     i_cnt_en      : decrement by one while non-zero
//     o_tc          : count is zero (terminal count)
module lv_bist_tmr #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_cnt_en,
    output logic         o_tc
);

    logic [W-1:0] cnt;

    // Sticks at zero instead of wrapping, so a stalled engine can never
    // make the watchdog appear to restart.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_cnt_en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_tc = (cnt == '0);

endmodule

// File: rtl/lv_bist_ctrl.sv
// lv_bist_ctrl
//   Sequencer in front of the LV logic BIST engine. Runs one BIST pass per
//   attempt, retries failed passes up to BIST_MAX_TRY attempts in total and
//   publishes a sticky pass/fail verdict plus the last attempt's fail code.
//   Ports:
//     i_clk, i_rst          : clock, synchronous active-high reset
//     i_bist_start         : start pulse (accepted in IDLE and DONE only)
//     o_bist_en            : registered engine enable, high in RUN
//     i_lv_bist_done       : engine done level
//     i_owt_bist_rult      : engine OWT fail flag
//     i_scan_reg_bist_rult : engine scan-reg fail flag
//     i_hv_intb_bist_rult  : engine INTB fail flag
//     o_bist_busy          : high in RUN, EVAL and GAP
//     o_bist_pass/fail     : sticky, mutually exclusive verdict
//     o_bist_fail_code     : [0] owt, [1] scan, [2] intb, [3] watchdog
//     o_bist_try_cnt       : number of attempts started
//     o_bist_cmplt         : one-cycle pulse on entering DONE
//     o_bist_state         : current FSM state (debug)
//
// Handshake: a start pulse seen in IDLE/DONE begins an attempt; o_bist_en
// is the request and stays high until the engine raises i_lv_bist_done
// (flags are valid in that same cycle) or the watchdog expires; o_bist_en
// then drops for at least one cycle before any retry.
module lv_bist_ctrl
    import lv_bist_pkg::*;
#(
    parameter int BIST_MAX_TRY = 2,
    parameter int BIST_GAP_CYC = 8,
    parameter int BIST_WDG_CYC = 4096
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_bist_start,
    output logic                              o_bist_en,
    input  logic                              i_lv_bist_done,
    input  logic                              i_owt_bist_rult,
    input  logic                              i_scan_reg_bist_rult,
    input  logic                              i_hv_intb_bist_rult,
    output logic                              o_bist_busy,
    output logic                              o_bist_pass,
    output logic                              o_bist_fail,
    output logic [BIST_FC_W-1:0]              o_bist_fail_code,
    output logic [$clog2(BIST_MAX_TRY+1)-1:0] o_bist_try_cnt,
    output logic                              o_bist_cmplt,
    output logic [2:0]                        o_bist_state
);

    localparam int TRY_W = $clog2(BIST_MAX_TRY + 1);
    localparam int TMR_W = $clog2(max2(BIST_WDG_CYC, BIST_GAP_CYC));

    // Loaded with N-1 so terminal count lands on the N-th cycle in state.
    localparam logic [TMR_W-1:0] WDG_LOAD = TMR_W'(BIST_WDG_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(BIST_GAP_CYC - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(BIST_MAX_TRY);

    lv_bist_st_e      state;
    lv_bist_st_e      state_nxt;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_tc;
    logic             start_acc;
    logic             run_exit;
    logic             gap_exit;
    logic             eval_done;

    lv_bist_tmr #(
        .W (TMR_W)
    ) u_tmr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_load_val),
        .i_cnt_en   ((state == ST_RUN) || (state == ST_GAP)),
        .o_tc       (tmr_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        start_acc    = 1'b0;
        run_exit     = 1'b0;
        gap_exit     = 1'b0;
        eval_done    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (i_bist_start) begin
                    state_nxt    = ST_RUN;
                    start_acc    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = WDG_LOAD;
                end
            end
            ST_RUN: begin
                // Done takes priority over a coincident watchdog expiry.
                if (i_lv_bist_done || tmr_tc) begin
                    state_nxt = ST_EVAL;
                    run_exit  = 1'b1;
                end
            end
            ST_EVAL: begin
                if ((o_bist_fail_code != '0) && (o_bist_try_cnt < TRY_MAX)) begin
                    state_nxt    = ST_GAP;
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LOAD;
                end else begin
                    state_nxt = ST_DONE;
                    eval_done = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    state_nxt    = ST_RUN;
                    gap_exit     = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = WDG_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bist_en        <= 1'b0;
            o_bist_pass      <= 1'b0;
            o_bist_fail      <= 1'b0;
            o_bist_fail_code <= '0;
            o_bist_try_cnt   <= '0;
            o_bist_cmplt     <= 1'b0;
        end else begin
            o_bist_en    <= (state_nxt == ST_RUN);
            o_bist_cmplt <= eval_done;

            if (start_acc) begin
                o_bist_pass      <= 1'b0;
                o_bist_fail      <= 1'b0;
                o_bist_fail_code <= '0;
                o_bist_try_cnt   <= TRY_W'(1);
            end

            if (run_exit) begin
                if (i_lv_bist_done) begin
                    o_bist_fail_code[BIST_FC_OWT]  <= i_owt_bist_rult;
                    o_bist_fail_code[BIST_FC_SCAN] <= i_scan_reg_bist_rult;
                    o_bist_fail_code[BIST_FC_INTB] <= i_hv_intb_bist_rult;
                    o_bist_fail_code[BIST_FC_WDG]  <= 1'b0;
                end else begin
                    o_bist_fail_code              <= '0;
                    o_bist_fail_code[BIST_FC_WDG] <= 1'b1;
                end
            end

            if (gap_exit && (o_bist_try_cnt < TRY_MAX)) begin
                o_bist_try_cnt <= o_bist_try_cnt + TRY_W'(1);
            end

            if (eval_done) begin
                o_bist_pass <= (o_bist_fail_code == '0);
                o_bist_fail <= (o_bist_fail_code != '0);
            end
        end
    end

    assign o_bist_busy  = (state == ST_RUN) || (state == ST_EVAL) || (state == ST_GAP);
    assign o_bist_state = state;

endmodule

// File: tb/tb_lv_bist_ctrl.sv
module tb_lv_bist_ctrl;

    localparam int MAX_TRY = 2;
    localparam int GAP     = 8;
    localparam int WDG     = 256;
    localparam int WDG_W   = 64;
    localparam int TRY_W   = $clog2(MAX_TRY + 1);

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_w;
    logic done;
    logic owt;
    logic scan;
    logic intb;

    logic             o_bist_en;
    logic             o_bist_busy;
    logic             o_bist_pass;
    logic             o_bist_fail;
    logic [3:0]       o_bist_fail_code;
    logic [TRY_W-1:0] o_bist_try_cnt;
    logic             o_bist_cmplt;
    logic [2:0]       o_bist_state;

    logic       w_en;
    logic       w_busy;
    logic       w_pass;
    logic       w_fail;
    logic [3:0] w_code;
    logic       w_try;
    logic       w_cmplt;
    logic [2:0] w_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    int         att_dly[MAX_TRY];
    logic [2:0] att_flg[MAX_TRY];

    always #5 clk = ~clk;

    lv_bist_ctrl #(
        .BIST_MAX_TRY (MAX_TRY),
        .BIST_GAP_CYC (GAP),
        .BIST_WDG_CYC (WDG)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_bist_start         (start),
        .o_bist_en            (o_bist_en),
        .i_lv_bist_done       (done),
        .i_owt_bist_rult      (owt),
        .i_scan_reg_bist_rult (scan),
        .i_hv_intb_bist_rult  (intb),
        .o_bist_busy          (o_bist_busy),
        .o_bist_pass          (o_bist_pass),
        .o_bist_fail          (o_bist_fail),
        .o_bist_fail_code     (o_bist_fail_code),
        .o_bist_try_cnt       (o_bist_try_cnt),
        .o_bist_cmplt         (o_bist_cmplt),
        .o_bist_state         (o_bist_state)
    );

    lv_bist_ctrl #(
        .BIST_MAX_TRY (1),
        .BIST_GAP_CYC (GAP),
        .BIST_WDG_CYC (WDG_W)
    ) dut_w (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_bist_start         (start_w),
        .o_bist_en            (w_en),
        .i_lv_bist_done       (done),
        .i_owt_bist_rult      (owt),
        .i_scan_reg_bist_rult (scan),
        .i_hv_intb_bist_rult  (intb),
        .o_bist_busy          (w_busy),
        .o_bist_pass          (w_pass),
        .o_bist_fail          (w_fail),
        .o_bist_fail_code     (w_code),
        .o_bist_try_cnt       (w_try),
        .o_bist_cmplt         (w_cmplt),
        .o_bist_state         (w_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: an attempt whose done arrives within the watchdog
    // window reports its flags; otherwise it is a watchdog failure.
    function automatic logic [3:0] att_code(input int i);
        if (att_dly[i] >= 0 && att_dly[i] < WDG) return {1'b0, att_flg[i]};
        return 4'b1000;
    endfunction

    // Verdict word: {pass, fail, code[3:0], tries[1:0]}.
    function automatic logic [7:0] predict();
        logic [3:0] c;
        int         t;
        c = '0;
        t = 0;
        for (int i = 0; i < MAX_TRY; i++) begin
            t = i + 1;
            c = att_code(i);
            if (c == 4'd0) break;
        end
        return {(c == 4'd0), (c != 4'd0), c, 2'(t)};
    endfunction

    task automatic run_session(input bit poke);
        logic [3:0] c;
        int         k;
        int         low;
        int         exp_len;
        bit         retry;
        exp_q.push_back(predict());
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_en", o_bist_en, 1);
        chk("start_clear", {o_bist_pass, o_bist_fail, o_bist_fail_code, o_bist_try_cnt}, 8'h01);
        for (int a = 0; a < MAX_TRY; a++) begin
            c = att_code(a);
            exp_len = (att_dly[a] >= 0 && att_dly[a] < WDG) ? att_dly[a] + 1 : WDG;
            k = 0;
            while (o_bist_en && k < WDG + 4) begin
                if (k == att_dly[a]) begin
                    done = 1'b1;
                    {intb, scan, owt} = att_flg[a];
                end
                tick();
                done = 1'b0;
                {intb, scan, owt} = 3'b000;
                k++;
            end
            chk("run_len", k, exp_len);
            chk("eval_code", o_bist_fail_code, c);
            chk("eval_busy", o_bist_busy, 1);
            retry = (c != 4'd0) && (a + 1 < MAX_TRY);
            if (!retry) break;
            low = 1;
            for (int j = 0; j < GAP + 8 && !o_bist_en; j++) begin
                start = poke && (j == 2);
                tick();
                start = 1'b0;
                if (!o_bist_en) low++;
            end
            // EVAL cycle plus the GAP cycles.
            chk("gap_len", low, GAP + 1);
            chk("retry_try", o_bist_try_cnt, a + 2);
        end
        tick();
        chk("cmplt_pulse", o_bist_cmplt, 1);
        chk("verdict", {o_bist_pass, o_bist_fail, o_bist_fail_code, o_bist_try_cnt}, exp_q.pop_front());
        tick();
        chk("cmplt_once", o_bist_cmplt, 0);
        chk("done_idle", {o_bist_en, o_bist_busy}, 0);
    endtask

    initial begin
        int sel;
        int k;
        rst = 1'b1;
        start = 1'b0;
        start_w = 1'b0;
        done = 1'b0;
        owt = 1'b0;
        scan = 1'b0;
        intb = 1'b0;

        repeat (3) tick();
        chk("rst_main", {o_bist_en, o_bist_busy, o_bist_pass, o_bist_fail, o_bist_fail_code,
                         o_bist_try_cnt, o_bist_cmplt, o_bist_state}, 0);
        chk("rst_w", {w_en, w_busy, w_pass, w_fail, w_code, w_try, w_cmplt, w_state}, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_start", {o_bist_en, o_bist_busy}, 0);

        // Clean pass, done after 100 cycles.
        att_dly[0] = 99; att_flg[0] = 3'b000;
        att_dly[1] = 0;  att_flg[1] = 3'b000;
        run_session(1'b0);

        // OWT failure then clean retry, with a start pulse in GAP.
        att_dly[0] = 20; att_flg[0] = 3'b001;
        att_dly[1] = 15; att_flg[1] = 3'b000;
        run_session(1'b1);

        // Scan + INTB fail on both attempts.
        att_dly[0] = 30; att_flg[0] = 3'b110;
        att_dly[1] = 12; att_flg[1] = 3'b110;
        run_session(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fail_hold_en", {o_bist_en, o_bist_fail, o_bist_fail_code}, 6'b0_1_0110);
        end

        // Done coincides with the watchdog terminal count.
        att_dly[0] = WDG - 1; att_flg[0] = 3'b000;
        att_dly[1] = 0;       att_flg[1] = 3'b000;
        run_session(1'b0);

        // Watchdog on first attempt, clean second.
        att_dly[0] = -1; att_flg[0] = 3'b111;
        att_dly[1] = 5;  att_flg[1] = 3'b000;
        run_session(1'b0);

        // Reset while holding a pass verdict.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_done", {o_bist_pass, o_bist_fail, o_bist_fail_code, o_bist_try_cnt}, 0);

        // Reset mid-RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("midrun_en", o_bist_en, 1);
        rst = 1'b1;
        tick();
        chk("rst_midrun", {o_bist_en, o_bist_busy, o_bist_pass, o_bist_fail, o_bist_fail_code,
                           o_bist_try_cnt, o_bist_cmplt}, 0);
        rst = 1'b0;
        tick();
        chk("rst_midrun_idle", {o_bist_en, o_bist_busy}, 0);

        // Watchdog-only instance: single attempt, done never asserted.
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        k = 0;
        while (w_en && k < WDG_W + 4) begin
            tick();
            k++;
        end
        chk("w_run_len", k, WDG_W);
        chk("w_code", w_code, 4'b1000);
        tick();
        chk("w_verdict", {w_pass, w_fail, w_cmplt, w_try}, 4'b0111);

        // Randomized sessions.
        for (int s = 0; s < 24; s++) begin
            for (int a = 0; a < MAX_TRY; a++) begin
                att_dly[a] = int'($urandom_range(0, 40));
                sel = int'($urandom_range(0, 9));
                if (sel == 0) att_dly[a] = WDG - 1;
                else if (sel == 1) att_dly[a] = -1;
                att_flg[a] = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            end
            run_session($urandom_range(0, 1) != 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
